// File: rtl/apple_iie_video_scanner.sv
// IOU video scanner: horizontal/vertical scan counters, blanking and the display RAM scan address.
// Optional sticky VBL interrupt is built only when APPLE_IIE_VBL_IRQ_EN is defined.
module apple_iie_video_scanner #(
   parameter int H_TOTAL   = 65,
   parameter int V_TOTAL   = 262,
   parameter int MIXED_ROW = 160
) (
   input  logic        clk_phi_0,
   input  logic        reset_n,
   input  logic        soft_switch_text,
   input  logic        soft_switch_mixed,
   input  logic        soft_switch_hires,
   input  logic        soft_switch_80store,
   input  logic        soft_switch_page2,
   input  logic        vbl_clr,
   output logic        h0,
   output logic        vc,
   output logic [15:0] vid_a,
   output logic        sega,
   output logic        segb,
   output logic        hblank_n,
   output logic        vblank_n,
   output logic        frame_start,
   output logic        vbl_irq
);

   localparam logic [6:0] H_LAST  = 7'(H_TOTAL - 1);
   localparam logic [6:0] H_START = 7'(H_TOTAL - 64);
   localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
   localparam logic [8:0] MIX_ROW = 9'(MIXED_ROW);
   localparam logic [8:0] V_VIS   = 9'd192;

   logic [6:0] h_count;
   logic [8:0] v_count;
   logic       sh_text;
   logic       sh_mixed;
   logic       sh_hires;
   logic       sh_store80;
   logic       sh_page2;

   logic       h_wrap;
   logic [5:0] h6;
   logic       eff_text;
   logic       tl;
   logic [3:0] s;
   logic       p1;
   logic       p2;
   logic       a10, a11, a12, a13, a14;

   assign h_wrap = (h_count == H_LAST);

   always_ff @(posedge clk_phi_0 or negedge reset_n) begin
      if (!reset_n) begin
         h_count <= '0;
         v_count <= '0;
      end else if (h_wrap) begin
         h_count <= '0;
         v_count <= (v_count == V_LAST) ? '0 : v_count + 9'd1;
      end else begin
         h_count <= h_count + 7'd1;
      end
   end

   // Mode switches are sampled on the last cycle of a line so a whole line is rendered in one mode.
   always_ff @(posedge clk_phi_0 or negedge reset_n) begin
      if (!reset_n) begin
         sh_text    <= 1'b1;
         sh_mixed   <= 1'b0;
         sh_hires   <= 1'b0;
         sh_store80 <= 1'b0;
         sh_page2   <= 1'b0;
      end else if (h_wrap) begin
         sh_text    <= soft_switch_text;
         sh_mixed   <= soft_switch_mixed;
         sh_hires   <= soft_switch_hires;
         sh_store80 <= soft_switch_80store;
         sh_page2   <= soft_switch_page2;
      end
   end

   always_comb begin
      h6       = (h_count < H_START) ? 6'd0 : 6'(h_count - H_START);
      eff_text = sh_text | (sh_mixed & (v_count >= MIX_ROW));
      tl       = eff_text | ~sh_hires;
      // Row-interleave adder: folds 40*v[7:6] - 24 into the column bits.
      s        = {3'b000, v_count[6]}
               + {~h6[5], v_count[6], h6[4], h6[3]}
               + {v_count[7], ~h6[5], v_count[7], 1'b1};
      p1       = sh_store80 | ~sh_page2;
      p2       = ~sh_store80 & sh_page2;
      a10      = tl ? p1 : v_count[0];
      a11      = tl ? p2 : v_count[1];
      a12      = tl ? 1'b0 : v_count[2];
      a13      = tl ? 1'b0 : p1;
      a14      = tl ? 1'b0 : p2;
   end

   assign vid_a       = {1'b0, a14, a13, a12, a11, a10, v_count[5:3], s, h6[2:0]};
   assign h0          = h6[0];
   assign vc          = v_count[2];
   assign sega        = eff_text ? v_count[0] : h6[0];
   assign segb        = eff_text ? v_count[1] : ~sh_hires;
   assign hblank_n    = (h6 >= 6'd24) && (h_count >= H_START);
   assign vblank_n    = (v_count < V_VIS);
   assign frame_start = (h_count == 7'd0) && (v_count == 9'd0);

`ifdef APPLE_IIE_VBL_IRQ_EN
   // Sticky flag: set at the first blanked line start; a coincident clear loses to the set.
   logic vbl_irq_q;

   always_ff @(posedge clk_phi_0 or negedge reset_n) begin
      if (!reset_n) begin
         vbl_irq_q <= 1'b0;
      end else if ((h_count == 7'd0) && (v_count == V_VIS)) begin
         vbl_irq_q <= 1'b1;
      end else if (vbl_clr) begin
         vbl_irq_q <= 1'b0;
      end
   end

   assign vbl_irq = vbl_irq_q;
`else
   logic unused_vbl_clr;

   assign unused_vbl_clr = vbl_clr;
   assign vbl_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_apple_iie_video_scanner.sv
// Scoreboard bench for apple_iie_video_scanner: a cycle-count reference model predicts every output vector.
// Define APPLE_IIE_VBL_IRQ_EN for both RTL and bench to exercise the sticky VBL interrupt.
module tb_apple_iie_video_scanner;

   localparam int H_TOTAL   = 65;
   localparam int V_TOTAL   = 262;
   localparam int MIXED_ROW = 160;
   localparam int FRAME     = H_TOTAL * V_TOTAL;

   logic        clk_phi_0 = 1'b0;
   logic        reset_n   = 1'b0;
   logic        sw_text   = 1'b1;
   logic        sw_mixed  = 1'b0;
   logic        sw_hires  = 1'b0;
   logic        sw_80     = 1'b0;
   logic        sw_page2  = 1'b0;
   logic        vbl_clr   = 1'b0;
   logic        h0, vc, sega, segb, hblank_n, vblank_n, frame_start, vbl_irq;
   logic [15:0] vid_a;

   logic [23:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   // model state: cycles since reset release, line-latched modes, irq flag
   int t;
   bit m_text, m_mixed, m_hires, m_80, m_page2, m_irq;

   apple_iie_video_scanner #(
      .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .MIXED_ROW(MIXED_ROW)
   ) dut (
      .clk_phi_0(clk_phi_0), .reset_n(reset_n),
      .soft_switch_text(sw_text), .soft_switch_mixed(sw_mixed), .soft_switch_hires(sw_hires),
      .soft_switch_80store(sw_80), .soft_switch_page2(sw_page2), .vbl_clr(vbl_clr),
      .h0(h0), .vc(vc), .vid_a(vid_a), .sega(sega), .segb(segb),
      .hblank_n(hblank_n), .vblank_n(vblank_n), .frame_start(frame_start), .vbl_irq(vbl_irq)
   );

   always #5 clk_phi_0 = ~clk_phi_0;

   task automatic model_reset();
      t = 0;
      m_text = 1; m_mixed = 0; m_hires = 0; m_80 = 0; m_page2 = 0; m_irq = 0;
   endtask

   // Apple II memory map: page base + 128*(row%8) + 40*(row/8) + column, hires adds 1024*(line%8).
   function automatic logic [23:0] model_out();
      int h, v, h6, low7, addr, base;
      bit eff, pg2, a_tl, sa, sb, hb, vb, fs, irq;
      h    = t % H_TOTAL;
      v    = (t / H_TOTAL) % V_TOTAL;
      h6   = (h < H_TOTAL - 64) ? 0 : h - (H_TOTAL - 64);
      eff  = m_text || (m_mixed && v >= MIXED_ROW);
      pg2  = m_page2 && !m_80;
      a_tl = eff || !m_hires;
      low7 = (40 * ((v / 64) % 4) + h6 - 24 + 128) % 128;
      if (a_tl) begin
         base = pg2 ? 'h0800 : 'h0400;
         addr = base + 128 * ((v / 8) % 8) + low7;
      end else begin
         base = pg2 ? 'h4000 : 'h2000;
         addr = base + 1024 * (v % 8) + 128 * ((v / 8) % 8) + low7;
      end
      sa  = eff ? (v % 2 == 1) : (h6 % 2 == 1);
      sb  = eff ? ((v / 2) % 2 == 1) : !m_hires;
      hb  = (h6 >= 24) && (h >= H_TOTAL - 64);
      vb  = (v < 192);
      fs  = (h == 0) && (v == 0);
`ifdef APPLE_IIE_VBL_IRQ_EN
      irq = m_irq;
`else
      irq = 0;
`endif
      return {(h6 % 2 == 1), ((v / 4) % 2 == 1), 16'(addr), sa, sb, hb, vb, fs, irq};
   endfunction

   // Advance the model across one active edge using the inputs that were held during it.
   task automatic model_step();
      int h, v;
      if (!reset_n) begin
         model_reset();
      end else begin
         h = t % H_TOTAL;
         v = (t / H_TOTAL) % V_TOTAL;
         if (h == 0 && v == 192) m_irq = 1;
         else if (vbl_clr) m_irq = 0;
         if (h == H_TOTAL - 1) begin
            m_text = sw_text; m_mixed = sw_mixed; m_hires = sw_hires;
            m_80 = sw_80; m_page2 = sw_page2;
         end
         t++;
      end
   endtask

   task automatic set_modes(input bit tx, input bit mx, input bit hr, input bit s80, input bit pg);
      sw_text = tx; sw_mixed = mx; sw_hires = hr; sw_80 = s80; sw_page2 = pg;
   endtask

   task automatic next_clr();
      int h, v;
      h = t % H_TOTAL;
      v = (t / H_TOTAL) % V_TOTAL;
      // force a clear onto the set cycle so set-beats-clear is hit every frame
      vbl_clr = (reset_n && h == 0 && v == 192) ? 1'b1 : ($urandom_range(0, 7) == 0);
   endtask

   task automatic run_cycles(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_phi_0);
         #1;
         model_step();
         if (rnd && $urandom_range(0, 99) == 0)
            set_modes($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 1));
         next_clr();
         exp_q.push_back(model_out());
      end
   endtask

   // Reset is asserted between edges so the asynchronous clear is visible before the next edge.
   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_phi_0);
         #1;
         model_step();
         reset_n = 1'b0;
         model_reset();
         vbl_clr = 1'b0;
         exp_q.push_back(model_out());
      end
      @(posedge clk_phi_0);
      #1;
      model_step();
      reset_n = 1'b1;
      next_clr();
      exp_q.push_back(model_out());
   endtask

   initial begin : monitor
      logic [23:0] exp_v, act_v;
      forever begin
         @(negedge clk_phi_0);
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {h0, vc, vid_a, sega, segb, hblank_n, vblank_n, frame_start, vbl_irq};
            n_checks++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL scan_out @%0t: got h0/vc/vid_a/sega/segb/hbl/vbl/fs/irq=%h, expected %h",
                          $time, act_v, exp_v);
         end
      end
   end

   initial begin : driver
      model_reset();
      reset_cycles(3);
      // text page 1, then PAGE2 flipped mid-line on line 5
      run_cycles(5 * H_TOTAL + 30, 1'b0);
      sw_page2 = 1'b1;
      run_cycles(FRAME + 100, 1'b0);
      // mixed + hires page 1 across the whole frame, including the split line
      set_modes(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      run_cycles(FRAME, 1'b0);
      // hires page 2
      set_modes(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      run_cycles(2000, 1'b0);
      run_cycles(FRAME, 1'b1);
      reset_cycles(2);
      run_cycles(1000, 1'b1);
      @(negedge clk_phi_0);
      @(negedge clk_phi_0);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
